wide_add_sequencer: RTL and testbench

WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

---
 rtl/wide_add_sequencer.sv | 130 +++++++++++++
 tb/tb_wide_add_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// Multi-cycle W-bit add/subtract that streams one N-bit word per cycle through
// a shared external combinational adder, producing a registered sum and NZCV flags.

module wide_add_sequencer_word #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_we,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    o_q <= '0;
    else if (i_we) o_q <= i_d;
  end
endmodule

module wide_add_sequencer #(
  parameter  int N     = 8,
  parameter  int WORDS = 4,
  localparam int W     = N * WORDS,
  localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         sub_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] sum_o,
  output logic [3:0]   flags_o,
  output logic [N-1:0] add_a_o,
  output logic [N-1:0] add_b_o,
  output logic         add_cin_o,
  input  logic [N-1:0] add_sum_i,
  input  logic         add_cout_i
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   r_state, w_next;
  logic [WORDS-1:0][N-1:0]  r_a, r_b;
  logic                     r_sub;
  logic [KW-1:0]            r_k;
  logic                     r_carry;
  logic                     r_zacc;
  logic [3:0]               r_flags;

  logic                     w_run, w_last, w_bmsb;
  logic [WORDS-1:0]         w_sum_we;
  logic [WORDS-1:0][N-1:0]  w_sum_q;

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_k == KW'(WORDS - 1));
  // Sign bit of the operand actually fed to the adder (after subtract inversion).
  assign w_bmsb = r_b[WORDS-1][N-1] ^ r_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    add_a_o   = '0;
    add_b_o   = '0;
    add_cin_o = 1'b0;
    case (r_state)
      S_IDLE: if (start_i) w_next = S_RUN;
      S_RUN: begin
        busy_o    = 1'b1;
        add_a_o   = r_a[r_k];
        add_b_o   = r_b[r_k] ^ {N{r_sub}};
        add_cin_o = r_carry;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
      r_flags <= 4'b0000;
    end else if (r_state == S_IDLE && start_i) begin
      r_a     <= a_i;
      r_b     <= b_i;
      r_sub   <= sub_i;
      r_k     <= '0;
      r_carry <= sub_i;
      r_zacc  <= 1'b1;
    end else if (w_run) begin
      r_carry <= add_cout_i;
      r_zacc  <= r_zacc & (add_sum_i == '0);
      // k parks on the last word rather than wrapping; the next start reloads it.
      if (!w_last) r_k <= r_k + KW'(1);
      else r_flags <= {add_sum_i[N-1],
                       r_zacc & (add_sum_i == '0),
                       add_cout_i,
                       (r_a[WORDS-1][N-1] == w_bmsb) && (add_sum_i[N-1] != r_a[WORDS-1][N-1])};
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_word
    assign w_sum_we[g] = w_run && (r_k == KW'(g));
    wide_add_sequencer_word #(.N(N)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_sum_we[g]),
      .i_d   (add_sum_i),
      .o_q   (w_sum_q[g])
    );
  end

  assign sum_o   = w_sum_q;
  assign flags_o = r_flags;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: spec vectors, randomized ops against an
// arithmetic reference model, ignored-start and mid-run reset sequences.

module tb_wide_add_sequencer;
  localparam int N = 8;
  localparam int WORDS = 4;
  localparam int W = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i, sub_i;
  logic [W-1:0] a_i, b_i;
  logic         busy_o, done_o;
  logic [W-1:0] sum_o;
  logic [3:0]   flags_o;
  logic [N-1:0] add_a_o, add_b_o, add_sum_i;
  logic         add_cin_o, add_cout_i;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External combinational adder.
  assign {add_cout_i, add_sum_i} = {1'b0, add_a_o} + {1'b0, add_b_o} + 9'(add_cin_o);

  wide_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .sub_i(sub_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o),
    .sum_o(sum_o), .flags_o(flags_o), .add_a_o(add_a_o), .add_b_o(add_b_o),
    .add_cin_o(add_cin_o), .add_sum_i(add_sum_i), .add_cout_i(add_cout_i)
  );

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic [3:0]  flags;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Whole-width reference: two's-complement add of A and (possibly inverted) B.
  function automatic void model(input logic sub, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] s, output logic [3:0] f);
    logic [32:0] full;
    logic [31:0] bb;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 33'(sub);
    s    = full[31:0];
    f    = {s[31], (s == 32'h0), full[32], (a[31] == bb[31]) && (s[31] != a[31])};
  endfunction

  // Runs one operation; returns with the bench sitting in the done_o cycle.
  task automatic run_op(input logic sub, input logic [31:0] a, input logic [31:0] b);
    int n, nb;
    @(negedge clk);
    start_i = 1'b1; sub_i = sub; a_i = a; b_i = b;
    @(posedge clk);
    #1;
    start_i = 1'b0; sub_i = 1'($urandom); a_i = $urandom; b_i = $urandom;
    @(negedge clk);
    chk("drv_a0", 64'(add_a_o), 64'(a[7:0]));
    chk("drv_b0", 64'(add_b_o), 64'(b[7:0] ^ {8{sub}}));
    chk("drv_cin0", 64'(add_cin_o), 64'(sub));
    n = 1; nb = 0;
    while (!done_o && n < 20) begin
      if (busy_o) nb++;
      @(negedge clk);
      n++;
    end
    chk("done_cycle", 64'(n), 64'(WORDS + 1));
    chk("busy_cycles", 64'(nb), 64'(WORDS));
    chk("drv_idle", {add_a_o, add_b_o, add_cin_o}, 64'h0);
  endtask

  vec_t        tbl[4];
  logic [31:0] es;
  logic [3:0]  ef;
  logic        rs;
  logic [31:0] ra, rb;
  int          ndone;

  initial begin
    tbl[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
    tbl[1] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
    tbl[2] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b1000};
    tbl[3] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011};

    rst_n = 1'b1; start_i = 1'b0; sub_i = 1'b0; a_i = '0; b_i = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_done", 64'(done_o), 64'h0);
    chk("rst_sum", 64'(sum_o), 64'h0);
    chk("rst_flags", 64'(flags_o), 64'h0);
    chk("rst_drv", {add_a_o, add_b_o, add_cin_o}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_op(tbl[i].sub, tbl[i].a, tbl[i].b);
      chk($sformatf("vec%0d_sum", i), 64'(sum_o), 64'(tbl[i].sum));
      chk($sformatf("vec%0d_flags", i), 64'(flags_o), 64'(tbl[i].flags));
    end

    // Starts pulsed in RUN and in DONE must be ignored.
    @(negedge clk);
    start_i = 1'b1; sub_i = 1'b0; a_i = 32'h1; b_i = 32'h1;
    @(posedge clk);
    #1 start_i = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done_o) ndone++;
      start_i = (c == 2 || c == 5);
      sub_i = 1'b1; a_i = 32'hDEAD_BEEF; b_i = 32'h1234_5678;
    end
    start_i = 1'b0;
    chk("ign_ndone", 64'(ndone), 64'd1);
    chk("ign_sum", 64'(sum_o), 64'h2);
    chk("ign_flags", 64'(flags_o), 64'h0);
    chk("ign_busy", 64'(busy_o), 64'h0);

    // Reset in the second RUN cycle discards the operation.
    @(negedge clk);
    start_i = 1'b1; sub_i = 1'b0; a_i = 32'h1234_5678; b_i = 32'h1111_1111;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(posedge clk);
    #1 chk("mid_word0", 64'(sum_o[7:0]), 64'h89);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_o), 64'h0);
    chk("mid_rst_done", 64'(done_o), 64'h0);
    chk("mid_rst_sum", 64'(sum_o), 64'h0);
    chk("mid_rst_flags", 64'(flags_o), 64'h0);
    chk("mid_rst_drv", {add_a_o, add_b_o, add_cin_o}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 32'h10, 32'h20);
    chk("post_rst_sum", 64'(sum_o), 64'h30);
    chk("post_rst_flags", 64'(flags_o), 64'h0);

    // Randomized operations, some with corner operands.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFF_FFFF;
      model(rs, ra, rb, es, ef);
      run_op(rs, ra, rb);
      chk($sformatf("rnd%0d_sum", i), 64'(sum_o), 64'(es));
      chk($sformatf("rnd%0d_flags", i), 64'(flags_o), 64'(ef));
      @(negedge clk);
      chk($sformatf("rnd%0d_hold", i), 64'(sum_o), 64'(es));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
